bldc_duty_slew_limiter: RTL
===========================

// Module: bldc_duty_slew_limiter
// PURPOSE
//  Conditions the signed duty-cycle command written by the host before it reaches the BLDC motor
//  stage's duty_cycle input. Ramps the magnitude toward the target at a fixed slew rate and forces
//  a pass through zero on every direction reversal. Includes a command watchdog that ramps the
//  motor to zero when the host stops sending commands. There is one instance per motor channel,
//  between the register file and the motor block.
// PARAMETERS
//  DUTY_WIDTH  10     duty word width: bit[DUTY_WIDTH-1]=direction, bits[DUTY_WIDTH-2:0]=magnitude
//  STEP        4      magnitude change per slew tick (LSBs), must be >=1
//  TICK_DIV    64     clocks per slew tick, must be >=2
//  WDT_CYCLES  18432  clocks without cmd_valid before timeout (1 ms at 18.432 MHz)
// PORTS
//  clk         in   1           system clock; all logic on rising edge
//  rst_n       in   1           asynchronous, active-low reset
//  en          in   1           channel enable; low forces output to zero
//  cmd_duty    in   DUTY_WIDTH  target duty, sign-magnitude
//  cmd_valid   in   1           1-clk strobe: latch cmd_duty, kick watchdog
//  duty_cycle  out  DUTY_WIDTH  slew-limited duty to motor stage, sign-magnitude
//  at_target   out  1           duty_cycle equals normalised target
//  reversing   out  1           ramping down toward zero for a direction change
//  timeout     out  1           watchdog expired; target forced to zero
// BEHAVIOUR
//  Reset: duty_cycle=0, at_target=0, reversing=0, timeout=0, target=0, prescaler=0,
//   watchdog=0, state=IDLE. All outputs are registered.
//  Normalisation: any word with magnitude 0 becomes all-zero (0x200 -> 0x000). This applies to
//   the latched target and to duty_cycle.
//  Prescaler: counts 0..TICK_DIV-1 while en=1 and pulses tick when the count is TICK_DIV-1. It
//   is held at 0 while en=0.
//  Target: latched on cmd_valid. A cmd_valid in the same clock as a tick does not affect that
//   tick; the new target takes effect on the next tick.
//  States:
//   IDLE: duty_cycle=0. Moves to RAMP on the first clock with en=1.
//   RAMP: on tick, if output mag=0 or output dir equals target dir:
//    - set dir to target dir;
//    - step mag toward target mag by STEP, clamped at target (no overshoot).
//    If dirs differ and output mag>0, go to REVERSE and set reversing=1.
//   REVERSE: on tick, mag <= max(mag-STEP, 0). When mag reaches 0:
//    - dir takes the current target dir;
//    - reversing=0;
//    - return to RAMP.
//    The dir bit never changes while mag is nonzero.
//   TIMEOUT: target is forced to 0, timeout=1, and the output ramps down at STEP per tick.
//    cmd_valid leaves TIMEOUT:
//     - latch the new target;
//     - timeout=0 on the next clock;
//     - go to RAMP (or REVERSE if the dir rule requires it).
//  Watchdog: counts clocks while en=1. It clears on cmd_valid and is held at 0 while en=0.
//   Reaching WDT_CYCLES-1 enters TIMEOUT. If cmd_valid arrives in the same clock as expiry,
//   cmd_valid wins and there is no timeout.
//  en=0 in any state: on the next clock,
//   - duty_cycle=0, reversing=0, timeout=0, at_target=0;
//   - target cleared;
//   - state=IDLE.
//   There is no ramp-down; the motor stage's own startup handles the restart.
//  at_target: updated every clock as (duty_cycle == target) && en. It is 1 while holding at 0
//   with target 0.
//  Latency: duty_cycle changes 1 clock after tick. cmd_valid to first output move takes at most
//   TICK_DIV+1 clocks.
//  Widths: magnitude arithmetic is done at DUTY_WIDTH bits, so addition cannot overflow and
//   subtraction saturates at 0. The maximum magnitude is 2^(DUTY_WIDTH-1)-1.
// TESTING (STEP=4, TICK_DIV=4, WDT_CYCLES=200, DUTY_WIDTH=10)
//  1 Ramp-up: en=1, cmd 0x064 -> mag +4 every 4 clk, 0x064 reached after 25 ticks,
//    at_target=1, dir=0 throughout.
//  2 Clamp: from 0, cmd 0x006 -> outputs 0x004 then 0x006 (never 0x008); cmd 0x002 from 0x006
//    -> 0x002 in one tick.
//  3 Reversal: at 0x064, cmd 0x250 -> reversing=1, mag falls to 0 in 25 ticks, dir bit stays 0,
//    then 0x204..0x250, reversing=0.
//  4 Watchdog: last cmd_valid then 200 idle clk -> timeout=1, ramp to 0x000; cmd_valid with
//    0x010 -> timeout=0 next clk, ramps to 0x010; cmd_valid on expiry clk -> no timeout.
//  5 Abort: en=0 mid-ramp at 0x040 -> duty_cycle=0 next clk, state IDLE; rst_n low mid-ramp
//    -> all outputs 0 with no clock edge.
//  6 Negative zero: cmd 0x200 -> target 0x000, output ramps to 0x000, at_target=1, dir bit 0.

Source files
------------

// File: rtl/bldc_duty_slew_limiter.sv
// -----------------------------------------------------------------------------
// bldc_duty_slew_limiter
//
// Conditions the sign-magnitude duty command from the host before it reaches
// the motor stage. The output magnitude moves toward the latched target by STEP
// LSBs once every TICK_DIV clocks. A direction change always ramps through
// zero first. A command watchdog forces the target to zero when the host stops
// writing.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          channel enable; low clears everything on the next clock
//   cmd_duty    target duty, bit[DUTY_WIDTH-1]=dir, low bits=magnitude
//   cmd_valid   one-clock strobe: latch cmd_duty and kick the watchdog
//   duty_cycle  slew-limited duty to the motor stage (registered)
//   at_target   duty_cycle equals the normalised target while enabled
//   reversing   ramping toward zero ahead of a direction change
//   timeout     watchdog expired; ramping toward zero
// -----------------------------------------------------------------------------
module bldc_duty_slew_limiter #(
    parameter int DUTY_WIDTH = 10,
    parameter int STEP       = 4,
    parameter int TICK_DIV   = 64,
    parameter int WDT_CYCLES = 18432
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DUTY_WIDTH-1:0] cmd_duty,
    input  logic                  cmd_valid,
    output logic [DUTY_WIDTH-1:0] duty_cycle,
    output logic                  at_target,
    output logic                  reversing,
    output logic                  timeout
);

    localparam int MW = DUTY_WIDTH - 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WW-1:0]         WDT_LAST   = WW'(WDT_CYCLES - 1);
    localparam logic [DUTY_WIDTH-1:0] STEP_W     = DUTY_WIDTH'(STEP);

    typedef enum logic [1:0] {IDLE, RAMP, REVERSE, TIMEOUT} state_t;

    state_t                state, state_next;
    logic [PW-1:0]         presc;
    logic [WW-1:0]         wdt;
    logic [DUTY_WIDTH-1:0] target, target_next, duty_next, cmd_norm;
    logic                  reversing_next, timeout_next, at_target_next;
    logic                  tick, expire;
    logic                  out_dir, tgt_dir;
    logic [DUTY_WIDTH-1:0] out_mag, tgt_mag, mag_up, mag_dn, ramp_mag;

    // A zero magnitude is always encoded as all-zero, whatever the dir bit.
    function automatic logic [DUTY_WIDTH-1:0] pack_duty(input logic dir,
                                                        input logic [DUTY_WIDTH-1:0] mag);
        pack_duty = (mag == '0) ? '0 : {dir, mag[MW-1:0]};
    endfunction

    // Magnitudes are widened to the full word so +STEP cannot wrap.
    assign out_dir  = duty_cycle[DUTY_WIDTH-1];
    assign out_mag  = {1'b0, duty_cycle[MW-1:0]};
    assign tgt_dir  = target[DUTY_WIDTH-1];
    assign tgt_mag  = {1'b0, target[MW-1:0]};
    assign mag_up   = out_mag + STEP_W;
    assign mag_dn   = (out_mag > STEP_W) ? (out_mag - STEP_W) : '0;
    assign cmd_norm = pack_duty(cmd_duty[DUTY_WIDTH-1], {1'b0, cmd_duty[MW-1:0]});
    assign tick     = (presc == PRESC_LAST);

    // One step toward the target magnitude, never overshooting it.
    always_comb begin
        ramp_mag = out_mag;
        if (out_mag < tgt_mag) begin
            ramp_mag = (mag_up > tgt_mag) ? tgt_mag : mag_up;
        end else if (out_mag > tgt_mag) begin
            ramp_mag = (mag_dn < tgt_mag) ? tgt_mag : mag_dn;
        end
    end

    // cmd_valid on the expiry clock counts as a kick, so no timeout then.
    assign expire = ((state == RAMP) || (state == REVERSE)) && (wdt == WDT_LAST) && !cmd_valid;

    always_comb begin
        state_next     = state;
        target_next    = target;
        duty_next      = duty_cycle;
        reversing_next = reversing;
        timeout_next   = timeout;
        at_target_next = 1'b0;
        if (!en) begin
            state_next     = IDLE;
            target_next    = '0;
            duty_next      = '0;
            reversing_next = 1'b0;
            timeout_next   = 1'b0;
        end else begin
            // The tick below always works from the old target, so a new
            // command only influences the following tick.
            if (cmd_valid) begin
                target_next = cmd_norm;
            end
            case (state)
                IDLE: begin
                    duty_next  = '0;
                    state_next = RAMP;
                end
                RAMP: begin
                    if (tick) begin
                        if ((out_mag == '0) || (out_dir == tgt_dir)) begin
                            duty_next = pack_duty(tgt_dir, ramp_mag);
                        end else begin
                            // The first reversal tick already steps down; if
                            // that lands on zero the reversal is complete.
                            duty_next = pack_duty(out_dir, mag_dn);
                            if (mag_dn != '0) begin
                                state_next     = REVERSE;
                                reversing_next = 1'b1;
                            end
                        end
                    end
                end
                REVERSE: begin
                    if (tick) begin
                        duty_next = pack_duty(out_dir, mag_dn);
                        if (mag_dn == '0) begin
                            state_next     = RAMP;
                            reversing_next = 1'b0;
                        end
                    end
                end
                default: begin // TIMEOUT
                    if (tick) begin
                        duty_next = pack_duty(out_dir, mag_dn);
                    end
                    if (cmd_valid) begin
                        timeout_next = 1'b0;
                        if ((duty_next != '0) && (duty_next[DUTY_WIDTH-1] != cmd_norm[DUTY_WIDTH-1])) begin
                            state_next     = REVERSE;
                            reversing_next = 1'b1;
                        end else begin
                            state_next = RAMP;
                        end
                    end else begin
                        target_next = '0;
                    end
                end
            endcase
            if (expire) begin
                state_next     = TIMEOUT;
                target_next    = '0;
                timeout_next   = 1'b1;
                reversing_next = 1'b0;
            end
            at_target_next = (duty_next == target_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            wdt        <= '0;
            target     <= '0;
            duty_cycle <= '0;
            at_target  <= 1'b0;
            reversing  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            target     <= target_next;
            duty_cycle <= duty_next;
            at_target  <= at_target_next;
            reversing  <= reversing_next;
            timeout    <= timeout_next;
            if (!en || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
            // Saturates at the expiry count so TIMEOUT is not re-entered.
            if (!en || cmd_valid) begin
                wdt <= '0;
            end else if (wdt != WDT_LAST) begin
                wdt <= wdt + 1'b1;
            end
        end
    end

endmodule
